// File: rtl/cpu_if_regfile_pkg.sv
// Shared constants and types for the CPU_IF responder register bank.
// Register offsets are byte offsets formed from address[7:2].
package cpu_if_regfile_pkg;

  localparam logic [7:0] REG_ID        = 8'h00;
  localparam logic [7:0] REG_SCRATCH   = 8'h04;
  localparam logic [7:0] REG_CTRL      = 8'h08;
  localparam logic [7:0] REG_STATUS    = 8'h0C;
  localparam logic [7:0] REG_IRQ_EN    = 8'h10;
  localparam logic [7:0] REG_ERR_COUNT = 8'h14;

  localparam logic [31:0] MISS_READ_VALUE  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_ID_VALUE = 32'h5453_0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/cpu_if_regfile_if.sv
// CPU_IF request/response bundle: single-cycle request pulses in,
// one-cycle completion pulse and held read data out.
interface cpu_if_regfile_if;

  logic        read;
  logic        write;
  logic [31:0] write_data;
  logic [31:2] address;
  logic [31:0] read_data;
  logic        access_complete;

  modport master (
    output read, write, write_data, address,
    input  read_data, access_complete
  );

  modport slave (
    input  read, write, write_data, address,
    output read_data, access_complete
  );

endinterface

// File: rtl/cpu_if_w1c_reg.sv
// Sticky event register: bits set by pulses, cleared by write-1-clear mask.
// A bit set and cleared in the same cycle stays set.
module cpu_if_w1c_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] set,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_r;

  // clear first, then OR in new events so a simultaneous set wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= {WIDTH{1'b0}};
    end else begin
      q_r <= (q_r & ~clr) | set;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/cpu_if_regfile.sv
// CPU_IF responder register bank (ID/SCRATCH/CTRL/STATUS/IRQ_EN) with a fixed
// completion latency. Optional ERR_COUNT register: CPU_IF_REGFILE_ERR_COUNT_EN.
module cpu_if_regfile
  import cpu_if_regfile_pkg::*;
#(
  parameter logic [31:0] ID_VALUE  = DEFAULT_ID_VALUE,
  parameter int          ACK_DELAY = 2,
  parameter logic [29:0] BASE_ADDR = 30'h0,
  parameter int          EVT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_if_regfile_if.slave      cpu_if,
  output logic [31:0]          ctrl_out,
  input  logic [EVT_WIDTH-1:0] evt_in,
  output logic                 irq
);

  localparam logic [3:0] CNT_LAST = 4'(ACK_DELAY - 1);

  state_t               state_r;
  state_t               state_s;
  logic [3:0]           cnt_r;
  logic [31:2]          addr_r;
  logic [31:0]          wdata_r;
  logic                 is_write_r;
  logic                 req_s;
  logic                 capture_s;
  logic                 access_s;
  logic [31:2]          acc_addr_s;
  logic [31:0]          acc_wdata_s;
  logic                 acc_write_s;
  logic [7:0]           offset_s;
  logic                 base_hit_s;
  logic                 hit_s;
  logic [31:0]          rd_val_s;
  logic                 wr_s;
  logic [EVT_WIDTH-1:0] w1c_mask_s;
  logic [EVT_WIDTH-1:0] status_s;
  logic [31:0]          read_data_r;
  logic                 complete_r;
  logic [31:0]          scratch_r;
  logic [31:0]          ctrl_r;
  logic [EVT_WIDTH-1:0] irq_en_r;
  logic                 irq_r;
`ifdef CPU_IF_REGFILE_ERR_COUNT_EN
  logic [15:0]          err_count_r;
  logic                 err_inc_s;
  logic                 err_clr_s;
`endif

  assign req_s = cpu_if.read | cpu_if.write;

  // next-state logic; the access itself happens on the edge entering DONE
  always_comb begin
    state_s   = state_r;
    capture_s = 1'b0;
    access_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          capture_s = 1'b1;
          if (ACK_DELAY == 0) begin
            state_s  = DONE;
            access_s = 1'b1;
          end else begin
            state_s  = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == CNT_LAST) begin
          state_s  = DONE;
          access_s = 1'b1;
        end else begin
          state_s  = WAIT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // with zero delay the access uses the live request, otherwise the captured one
  always_comb begin
    acc_addr_s  = addr_r;
    acc_wdata_s = wdata_r;
    acc_write_s = is_write_r;
    if (state_r == IDLE) begin
      acc_addr_s  = cpu_if.address;
      acc_wdata_s = cpu_if.write_data;
      acc_write_s = cpu_if.write;
    end else begin
      acc_addr_s  = addr_r;
      acc_wdata_s = wdata_r;
      acc_write_s = is_write_r;
    end
  end

  assign offset_s   = {acc_addr_s[7:2], 2'b00};
  assign base_hit_s = (acc_addr_s[31:8] == BASE_ADDR[29:6]);

  // address decode and read mux
  always_comb begin
    hit_s    = 1'b0;
    rd_val_s = MISS_READ_VALUE;
    if (base_hit_s) begin
      case (offset_s)
        REG_ID:        begin hit_s = 1'b1; rd_val_s = ID_VALUE;        end
        REG_SCRATCH:   begin hit_s = 1'b1; rd_val_s = scratch_r;       end
        REG_CTRL:      begin hit_s = 1'b1; rd_val_s = ctrl_r;          end
        REG_STATUS:    begin hit_s = 1'b1; rd_val_s = 32'(status_s);   end
        REG_IRQ_EN:    begin hit_s = 1'b1; rd_val_s = 32'(irq_en_r);   end
`ifdef CPU_IF_REGFILE_ERR_COUNT_EN
        REG_ERR_COUNT: begin hit_s = 1'b1; rd_val_s = {16'h0000, err_count_r}; end
`endif
        default:       begin hit_s = 1'b0; rd_val_s = MISS_READ_VALUE; end
      endcase
    end else begin
      hit_s    = 1'b0;
      rd_val_s = MISS_READ_VALUE;
    end
  end

  assign wr_s       = access_s & acc_write_s & hit_s;
  assign w1c_mask_s = (wr_s && offset_s == REG_STATUS) ? acc_wdata_s[EVT_WIDTH-1:0]
                                                       : {EVT_WIDTH{1'b0}};

  // FSM state, wait counter and request capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= 30'h0;
      wdata_r    <= 32'h0;
      is_write_r <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= (state_r == WAIT) ? cnt_r + 4'd1 : 4'd0;
      if (capture_s) begin
        addr_r     <= cpu_if.address;
        wdata_r    <= cpu_if.write_data;
        is_write_r <= cpu_if.write;
      end
    end
  end

  // register writes, held read data, completion pulse and interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read_data_r <= 32'h0;
      complete_r  <= 1'b0;
      scratch_r   <= 32'h0;
      ctrl_r      <= 32'h0;
      irq_en_r    <= {EVT_WIDTH{1'b0}};
      irq_r       <= 1'b0;
    end else begin
      complete_r <= access_s;
      irq_r      <= |(status_s & irq_en_r);
      if (access_s && !acc_write_s) begin
        read_data_r <= rd_val_s;
      end
      if (wr_s && offset_s == REG_SCRATCH) begin
        scratch_r <= acc_wdata_s;
      end
      if (wr_s && offset_s == REG_CTRL) begin
        ctrl_r <= acc_wdata_s;
      end
      if (wr_s && offset_s == REG_IRQ_EN) begin
        irq_en_r <= acc_wdata_s[EVT_WIDTH-1:0];
      end
    end
  end

  cpu_if_w1c_reg #(
    .WIDTH (EVT_WIDTH)
  ) u_status (
    .clk   (clk),
    .reset (reset),
    .set   (evt_in),
    .clr   (w1c_mask_s),
    .q     (status_s)
  );

`ifdef CPU_IF_REGFILE_ERR_COUNT_EN
  assign err_inc_s = (access_s & ~hit_s) | (req_s & (state_r != IDLE));
  assign err_clr_s = wr_s & (offset_s == REG_ERR_COUNT);

  // saturating error counter; a clear beats a same-cycle increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count_r <= 16'h0000;
    end else if (err_clr_s) begin
      err_count_r <= 16'h0000;
    end else if (err_inc_s && err_count_r != 16'hFFFF) begin
      err_count_r <= err_count_r + 16'h0001;
    end
  end
`endif

  assign cpu_if.read_data       = read_data_r;
  assign cpu_if.access_complete = complete_r;
  assign ctrl_out               = ctrl_r;
  assign irq                    = irq_r;

endmodule

// File: tb/tb_cpu_if_regfile.sv
// Randomised bench for cpu_if_regfile against a transaction-level model that
// tracks each accepted request by its due completion cycle.
module tb_cpu_if_regfile;

  localparam int          ACK_DELAY = 2;
  localparam int          EVT_WIDTH = 8;
  localparam logic [29:0] BASE_ADDR = 30'h0;
  localparam logic [31:0] ID_VALUE  = 32'h5453_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ctrl_out;
  logic [7:0]  evt_in;
  logic        irq;

  cpu_if_regfile_if cpu_if ();

  cpu_if_regfile #(
    .ID_VALUE  (ID_VALUE),
    .ACK_DELAY (ACK_DELAY),
    .BASE_ADDR (BASE_ADDR),
    .EVT_WIDTH (EVT_WIDTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_if   (cpu_if),
    .ctrl_out (ctrl_out),
    .evt_in   (evt_in),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_complete = 0;
  int last_cmp = -1;

  // reference model: values visible during the current cycle
  logic [31:0] m_scratch, m_ctrl, m_rdata;
  logic [7:0]  m_status, m_irq_en;
  logic [15:0] m_err;
  logic        m_irq, m_complete;
  bit          pend_valid;
  logic [31:0] pend_addr, pend_data;
  bit          pend_write;
  int          pend_due;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic void model_lookup(input logic [31:0] a, output bit hit, output logic [31:0] v);
    hit = 1'b0;
    v   = 32'h0;
    if (a[31:8] == BASE_ADDR[29:6]) begin
      case (a[7:0] & 8'hFC)
        8'h00: begin hit = 1'b1; v = ID_VALUE; end
        8'h04: begin hit = 1'b1; v = m_scratch; end
        8'h08: begin hit = 1'b1; v = m_ctrl; end
        8'h0C: begin hit = 1'b1; v = {24'h0, m_status}; end
        8'h10: begin hit = 1'b1; v = {24'h0, m_irq_en}; end
`ifdef CPU_IF_REGFILE_ERR_COUNT_EN
        8'h14: begin hit = 1'b1; v = {16'h0, m_err}; end
`endif
        default: begin hit = 1'b0; v = 32'h0; end
      endcase
    end
  endfunction

  // one clock cycle: check outputs, drive inputs, advance the model
  task automatic step(input bit rd, input bit wr, input logic [31:0] baddr,
                      input logic [31:0] wd, input logic [7:0] evt, input bit rst);
    bit          busy, acc, hit, inc, clr, req;
    logic [31:0] rv;
    logic [7:0]  w1c, off;
    logic [7:0]  n_status;
    check_eq("complete", {31'h0, cpu_if.access_complete}, {31'h0, m_complete});
    check_eq("read_data", cpu_if.read_data, m_rdata);
    check_eq("ctrl_out", ctrl_out, m_ctrl);
    check_eq("irq", {31'h0, irq}, {31'h0, m_irq});
    if (cpu_if.access_complete === 1'b1) begin
      n_complete++;
      last_cmp = cyc;
    end
    req = (rd | wr) & ~rst;
    reset             = rst;
    cpu_if.read       = rd & ~rst;
    cpu_if.write      = wr & ~rst;
    cpu_if.address    = baddr[31:2];
    cpu_if.write_data = wd;
    evt_in            = evt;
    if (rst) begin
      m_scratch = 32'h0; m_ctrl = 32'h0; m_rdata = 32'h0; m_status = 8'h0;
      m_irq_en = 8'h0; m_err = 16'h0; m_irq = 1'b0; m_complete = 1'b0;
      pend_valid = 1'b0;
    end else begin
      busy = pend_valid;
      if (pend_valid && pend_due == cyc) pend_valid = 1'b0;
      if (req && !busy) begin
        pend_valid = 1'b1;
        pend_addr  = baddr;
        pend_data  = wd;
        pend_write = wr;
        pend_due   = cyc + 1 + ACK_DELAY;
      end
      acc = pend_valid && (pend_due == cyc + 1);
      hit = 1'b0; rv = 32'h0; w1c = 8'h0; clr = 1'b0;
      off = pend_addr[7:0] & 8'hFC;
      if (acc) model_lookup(pend_addr, hit, rv);
      inc = (acc && !hit) || (req && busy);
      m_irq    = |(m_status & m_irq_en);
      n_status = m_status;
      if (acc && !pend_write) m_rdata = rv;
      if (acc && pend_write && hit) begin
        case (off)
          8'h04: m_scratch = pend_data;
          8'h08: m_ctrl = pend_data;
          8'h0C: w1c = pend_data[7:0];
          8'h10: m_irq_en = pend_data[7:0];
          8'h14: clr = 1'b1;
          default: ;
        endcase
      end
      m_status = (n_status & ~w1c) | evt;
      if (clr) m_err = 16'h0;
      else if (inc && m_err != 16'hFFFF) m_err = m_err + 16'h1;
      m_complete = acc;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b0);
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    step(1'b0, 1'b1, a, d, 8'h0, 1'b0);
  endtask

  task automatic rd_reg(input logic [31:0] a);
    step(1'b1, 1'b0, a, 32'h0, 8'h0, 1'b0);
  endtask

  logic [7:0] offs [9] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h40, 8'hFC};

  initial begin
    int t0, nc, r;
    bit rd, wr, rs;
    logic [23:0] upper;
    logic [7:0]  evt;
    reset = 1'b1;
    cpu_if.read = 1'b0; cpu_if.write = 1'b0;
    cpu_if.address = 30'h0; cpu_if.write_data = 32'h0;
    evt_in = 8'h0;
    m_scratch = 32'h0; m_ctrl = 32'h0; m_rdata = 32'h0; m_status = 8'h0;
    m_irq_en = 8'h0; m_err = 16'h0; m_irq = 1'b0; m_complete = 1'b0;
    pend_valid = 1'b0; pend_addr = 32'h0; pend_data = 32'h0; pend_write = 1'b0; pend_due = 0;
    @(negedge clk);
    step(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b1);

    // ID read latency and value
    t0 = cyc;
    rd_reg(32'h00);
    idle(4);
    check_eq("id_latency", 32'(last_cmp - t0), 32'd3);
    check_eq("id_value", cpu_if.read_data, 32'h5453_0001);

    // scratch round trip, then a CTRL write leaves read data alone
    wr_reg(32'h04, 32'hA5A5_5A5A); idle(4);
    rd_reg(32'h04); idle(4);
    check_eq("scratch_rd", cpu_if.read_data, 32'hA5A5_5A5A);
    wr_reg(32'h08, 32'h1); idle(4);
    check_eq("ctrl_out_1", ctrl_out, 32'h1);
    check_eq("rd_held", cpu_if.read_data, 32'hA5A5_5A5A);

    // sticky status, irq, and set-wins against a same-cycle W1C
    wr_reg(32'h10, 32'h1); idle(4);
    step(1'b0, 1'b0, 32'h0, 32'h0, 8'h01, 1'b0);
    idle(2);
    check_eq("irq_set", {31'h0, irq}, 32'h1);
    wr_reg(32'h0C, 32'h1);
    idle(1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 8'h01, 1'b0);
    idle(2);
    rd_reg(32'h0C); idle(4);
    check_eq("status_set_wins", cpu_if.read_data, 32'h1);
    wr_reg(32'h0C, 32'h1); idle(4);
    check_eq("irq_cleared", {31'h0, irq}, 32'h0);
    rd_reg(32'h0C); idle(4);
    check_eq("status_cleared", cpu_if.read_data, 32'h0);

    // miss read plus a request dropped while busy
    nc = n_complete;
    rd_reg(32'h40);
    rd_reg(32'h00);
    idle(5);
    check_eq("miss_one_pulse", 32'(n_complete - nc), 32'd1);
    check_eq("miss_rdata", cpu_if.read_data, 32'h0);
`ifdef CPU_IF_REGFILE_ERR_COUNT_EN
    rd_reg(32'h14); idle(4);
    check_eq("err_count", cpu_if.read_data, 32'd2);
`endif

    // simultaneous read and write is a write
    rd_reg(32'h04); idle(4);
    nc = n_complete;
    step(1'b1, 1'b1, 32'h04, 32'h0000_1234, 8'h0, 1'b0);
    idle(4);
    check_eq("rw_one_pulse", 32'(n_complete - nc), 32'd1);
    check_eq("rw_rd_unchanged", cpu_if.read_data, 32'hA5A5_5A5A);
    rd_reg(32'h04); idle(4);
    check_eq("rw_scratch", cpu_if.read_data, 32'h0000_1234);

    // reset during the wait of a write
    nc = n_complete;
    wr_reg(32'h04, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 32'h0, 32'h0, 8'h0, 1'b1);
    idle(3);
    check_eq("rst_no_pulse", 32'(n_complete - nc), 32'd0);
    rd_reg(32'h04); idle(4);
    check_eq("rst_scratch", cpu_if.read_data, 32'h0);
    check_eq("rst_next_pulse", 32'(n_complete - nc), 32'd1);

    // randomised traffic
    for (int i = 0; i < 3000; i++) begin
      r   = int'($urandom_range(0, 99));
      rd  = (r < 15) || (r >= 25 && r < 30);
      wr  = (r >= 15 && r < 30);
      evt = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      rs  = ($urandom_range(0, 599) == 0);
      upper = ($urandom_range(0, 7) == 0) ? 24'($urandom) : BASE_ADDR[29:6];
      step(rd, wr, {upper, offs[$urandom_range(0, 8)]}, $urandom, evt, rs);
    end
    idle(6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
